sp2x_access_ctl: RTL and testbench

- Access controller that drives a wrapped single-port RAM with a registered output: it generates a/we/re/di and consumes do.
- Gives one host a req/ack interface for reads and writes. Tracks the RAM's two-stage read latency and returns read data with a valid strobe.
- Clears the whole array after reset and on command.
- Sits between the datapath engine and the RAM wrapper instance.

---
 rtl/sp2x_access_ctl.sv | 155 +++++++++++++++
 tb/tb_sp2x_access_ctl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sp2x_access_ctl.sv
// sp2x_access_ctl
//   Access controller for a wrapped single-port RAM with a registered
//   output. It clears the whole array after reset and again on
//   init_start. It accepts host reads and writes on a req/ack handshake
//   at one access per cycle. Read data comes back with a valid strobe
//   three edges after acceptance.
//
//   Optional feature macro: RAMCTL_PARITY_EN
//     When defined, each stored word carries an even-parity bit in
//     ram_di[WIDTH]. Reads that fail the parity check raise hperr
//     together with hrvalid. When undefined, RW = WIDTH and hperr is
//     tied to 0.
//
// Ports
//   clk, rst_          clock; asynchronous active-low reset
//   init_start         pulse: re-clear the array (honoured only in READY)
//   init_done          high while the array is ready for host access
//   hreq/hwr/haddr/hwdata  host request (held until hack)
//   hack               request accepted this cycle (combinational)
//   hrvalid/hrdata     read response
//   herr               with hrvalid: read address was out of range
//   hperr              with hrvalid: parity error
//   ram_a/ram_we/ram_re/ram_di  registered RAM controls
//   ram_do             RAM registered read data
module sp2x_access_ctl #(
  parameter int ADDRBIT = 11,
  parameter int DEPTH   = 1536,
  parameter int WIDTH   = 32,
`ifdef RAMCTL_PARITY_EN
  localparam int RW     = WIDTH + 1
`else
  localparam int RW     = WIDTH
`endif
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               init_start,
  output logic               init_done,
  input  logic               hreq,
  input  logic               hwr,
  input  logic [ADDRBIT-1:0] haddr,
  input  logic [WIDTH-1:0]   hwdata,
  output logic               hack,
  output logic               hrvalid,
  output logic [WIDTH-1:0]   hrdata,
  output logic               herr,
  output logic               hperr,
  output logic [ADDRBIT-1:0] ram_a,
  output logic               ram_we,
  output logic               ram_re,
  output logic [RW-1:0]      ram_di,
  input  logic [RW-1:0]      ram_do
);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  // One extra bit so the compare also works when DEPTH == 2**ADDRBIT.
  localparam logic [ADDRBIT:0]   DEPTH_X = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] LAST_A  = ADDRBIT'(DEPTH - 1);

  state_t               state_q, state_d;
  logic [ADDRBIT-1:0]   cnt;
  logic                 init_last;
  logic                 in_range;

  // Read tracking: p0 is the accepted-read stage, and p1/p2 follow the
  // RAM's sample and output-register edges.
  logic                 vld_p0, vld_p1, vld_p2;
  logic                 oor_p0, oor_p1, oor_p2;

  function automatic logic [RW-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef RAMCTL_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign init_last = (cnt == LAST_A);
  assign in_range  = ({1'b0, haddr} < DEPTH_X);
  assign init_done = (state_q == READY);

  // Next state and host acknowledge. init_start wins over a same-cycle
  // request.
  always_comb begin
    state_d = state_q;
    hack    = 1'b0;
    case (state_q)
      INIT: begin
        if (init_last) state_d = READY;
      end
      READY: begin
        if (init_start) state_d = INIT;
        else            hack    = hreq;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= INIT;
      cnt     <= '0;
      ram_a   <= '0;
      ram_we  <= 1'b0;
      ram_re  <= 1'b0;
      ram_di  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      oor_p0  <= 1'b0;
      oor_p1  <= 1'b0;
      oor_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobes are single-cycle unless refreshed below.
      ram_we  <= 1'b0;
      ram_re  <= 1'b0;
      vld_p0  <= 1'b0;
      oor_p0  <= 1'b0;
      // p0 -> p1: RAM samples the address
      vld_p1  <= vld_p0;
      oor_p1  <= oor_p0;
      // p1 -> p2: wrapper registers the read data
      vld_p2  <= vld_p1;
      oor_p2  <= oor_p1;
      if (state_q == INIT) begin
        ram_a  <= cnt;
        ram_we <= 1'b1;
        ram_di <= '0;
        cnt    <= init_last ? '0 : cnt + 1'b1;
      end else if (init_start) begin
        cnt    <= '0;
      end else if (hack) begin
        // Out-of-range accesses are accepted but never reach the RAM.
        ram_a  <= haddr;
        ram_we <= hwr & in_range;
        ram_re <= ~hwr & in_range;
        ram_di <= encode(hwdata);
        vld_p0 <= ~hwr;
        oor_p0 <= ~in_range;
      end
    end
  end

  assign hrvalid = vld_p2;
  assign herr    = vld_p2 & oor_p2;
  assign hrdata  = (vld_p2 & ~oor_p2) ? ram_do[WIDTH-1:0] : '0;
`ifdef RAMCTL_PARITY_EN
  assign hperr   = vld_p2 & ~oor_p2 & (^ram_do);
`else
  assign hperr   = 1'b0;
`endif

endmodule

// File: tb/tb_sp2x_access_ctl.sv
// Testbench for sp2x_access_ctl. It models a registered-output
// single-port RAM. A queue holds the expected read responses, with the
// values and arrival cycles worked out by hand.
module tb_sp2x_access_ctl;
  localparam int AB = 11;
  localparam int W  = 32;
`ifdef RAMCTL_PARITY_EN
  localparam int RW = W + 1;
  localparam int NREADS = 9;
`else
  localparam int RW = W;
  localparam int NREADS = 8;
`endif

  logic          clk, rst_;
  logic          init_start, init_done;
  logic          hreq, hwr, hack, hrvalid, herr, hperr;
  logic [AB-1:0] haddr, ram_a;
  logic [W-1:0]  hwdata, hrdata;
  logic          ram_we, ram_re;
  logic [RW-1:0] ram_di, ram_do;

  sp2x_access_ctl dut (
    .clk(clk), .rst_(rst_), .init_start(init_start), .init_done(init_done),
    .hreq(hreq), .hwr(hwr), .haddr(haddr), .hwdata(hwdata), .hack(hack),
    .hrvalid(hrvalid), .hrdata(hrdata), .herr(herr), .hperr(hperr),
    .ram_a(ram_a), .ram_we(ram_we), .ram_re(ram_re), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: samples at one edge and registers its output at the next.
  logic [RW-1:0] mem [0:2047];
  logic [RW-1:0] rd1 = '0, do_r = '0, flip = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    if (ram_re) rd1 <= mem[ram_a];
    do_r <= rd1;
  end
  assign ram_do = do_r ^ flip;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, nvld = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         e;
    logic         p;
    int           due;
  } exp_t;
  exp_t q[$];
  exp_t cur;

  // Response monitor.
  always @(negedge clk) begin
    if (hrvalid === 1'b1) begin
      nvld++;
      if (q.size() == 0) chk("spurious_hrvalid", 1, 0);
      else begin
        cur = q.pop_front();
        chk("hrdata", hrdata, cur.d);
        chk("herr", herr, cur.e);
        chk("hperr", hperr, cur.p);
        chk("latency", cyc, cur.due);
      end
    end
  end

  // Called at a negedge. It presents one request, which is accepted at
  // the next posedge, and returns at the following negedge.
  task automatic issue(input logic wr, input logic [AB-1:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] ed, input logic ee, input logic ep);
    logic inr;
    inr = (a < 1536);
    hreq = 1'b1; hwr = wr; haddr = a; hwdata = d;
    #1;
    chk("hack", hack, 1);
    if (!wr) q.push_back('{ed, ee, ep, cyc + 3});
    @(negedge clk);
    chk("ram_we", ram_we, wr & inr);
    chk("ram_re", ram_re, ~wr & inr);
    if (inr) chk("ram_a", ram_a, a);
  endtask

  task automatic idle(input int n);
    hreq = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, 1536);
  endtask

  initial begin
    int bad;
    rst_ = 1'b0; init_start = 1'b0; hreq = 1'b0; hwr = 1'b0;
    haddr = '0; hwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_hrvalid", hrvalid, 0);
    chk("rst_hrdata", hrdata, 0);

    // Post-reset clear, with a host request pending throughout.
    hreq = 1'b1; hwr = 1'b1; haddr = 11'd2047;
    rst_ = 1'b1;
    bad = 0;
    for (int k = 0; k < 1536; k++) begin
      @(negedge clk);
      if (ram_we !== 1'b1 || ram_a !== AB'(k) || ram_di !== '0) bad++;
      if (k < 1535 && (hack !== 1'b0 || init_done !== 1'b0)) bad++;
    end
    hreq = 1'b0;
    chk("init_seq_bad", bad, 0);
    chk("init_done", init_done, 1);
    @(negedge clk);
    chk("we_after_init", ram_we, 0);

    // Write then read the same address back-to-back.
    issue(1'b1, 11'd5, 32'hDEADBEEF, 0, 0, 0);
    issue(1'b0, 11'd5, 0, 32'hDEADBEEF, 0, 0);
    idle(5);

    // Four writes, then four back-to-back reads.
    issue(1'b1, 11'd0, 32'h11, 0, 0, 0);
    issue(1'b1, 11'd1, 32'h22, 0, 0, 0);
    issue(1'b1, 11'd2, 32'h33, 0, 0, 0);
    issue(1'b1, 11'd3, 32'h44, 0, 0, 0);
    issue(1'b0, 11'd0, 0, 32'h11, 0, 0);
    issue(1'b0, 11'd1, 0, 32'h22, 0, 0);
    issue(1'b0, 11'd2, 0, 32'h33, 0, 0);
    issue(1'b0, 11'd3, 0, 32'h44, 0, 0);
    idle(5);

    // Range boundaries.
    issue(1'b0, 11'd1536, 0, 32'h0, 1, 0);
    issue(1'b1, 11'd2047, 32'hFFFFFFFF, 0, 0, 0);
    issue(1'b1, 11'd1535, 32'hA5, 0, 0, 0);
    issue(1'b0, 11'd1535, 0, 32'hA5, 0, 0);
    idle(5);

    // init_start beats a same-cycle write to address 5.
    hreq = 1'b1; hwr = 1'b1; haddr = 11'd5; hwdata = 32'h99; init_start = 1'b1;
    #1;
    chk("hack_vs_init_start", hack, 0);
    @(negedge clk);
    init_start = 1'b0; hreq = 1'b0;
    chk("we_at_init_start", ram_we, 0);
    chk("init_done_clear", init_done, 0);
    wait_init();
    @(negedge clk);
    issue(1'b0, 11'd5, 0, 32'h0, 0, 0);
    idle(5);

`ifdef RAMCTL_PARITY_EN
    // Corrupt bit 3 on the way back from the RAM.
    issue(1'b1, 11'd7, 32'h1, 0, 0, 0);
    flip = RW'(8);
    issue(1'b0, 11'd7, 0, 32'h9, 0, 1);
    idle(4);
    flip = '0;
    idle(2);
`endif

    // Asynchronous reset while two reads are in flight.
    issue(1'b1, 11'd9, 32'h5A5A, 0, 0, 0);
    issue(1'b0, 11'd9, 0, 32'h5A5A, 0, 0);
    issue(1'b0, 11'd9, 0, 32'h5A5A, 0, 0);
    hreq = 1'b0;
    rst_ = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hrvalid_in_reset", hrvalid, 0);
    end
    chk("init_done_in_reset", init_done, 0);
    rst_ = 1'b1;
    wait_init();
    idle(5);

    chk("pending_reads", q.size(), 0);
    chk("hrvalid_count", nvld, NREADS);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
